// File: rtl/mode_decode_stage_if.sv
// Handshake bundle between fetch and the decode stage, plus the decoded fields.
// The slave modport is the decode stage's view; master is the upstream/downstream driver view.
interface mode_decode_stage_if #(
   parameter int IW   = 9,
   parameter int OPW  = 5,
   parameter int RW   = 3,
   parameter int IMMW = 8
);
   logic            in_valid;
   logic            in_ready;
   logic [IW-1:0]   instr;
   logic            out_valid;
   logic            out_ready;
   logic [OPW-1:0]  opcode;
   logic [RW-1:0]   reg1;
   logic [RW-1:0]   reg2;
   logic [IMMW-1:0] immediate;
   logic            mode;

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, opcode, reg1, reg2, immediate, mode
   );

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, opcode, reg1, reg2, immediate, mode
   );
endinterface

// File: rtl/mode_decode_stage.sv
// Registered instruction decoder between fetch and register read: tracks the reg-reg/reg-imm
// mode flag, expands immediate indices through a programmable LUT, valid/ready on both sides.
module mode_decode_stage #(
   parameter int IW   = 9,
   parameter int OPW  = 5,
   parameter int RW   = 3,
   parameter int IMMW = 8,
   parameter int SWOP = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            lut_we,
   input  logic [RW-1:0]   lut_waddr,
   input  logic [IMMW-1:0] lut_wdata,
   output logic            mode_q,
   mode_decode_stage_if.slave bus
);

   localparam int FW    = (IW - OPW) / 2;
   localparam int DEPTH = 2 ** RW;

   typedef enum logic {MODE_RR = 1'b0, MODE_RI = 1'b1} mode_e;

   function automatic logic [IMMW-1:0] lut_init(input int idx);
      case (idx)
         0:       return IMMW'(0);
         1:       return IMMW'(1);
         2:       return IMMW'(4);
         3:       return IMMW'(8);
         4:       return IMMW'(16);
         5:       return IMMW'(32);
         6:       return IMMW'(64);
         7:       return IMMW'(127);
         default: return IMMW'(0);
      endcase
   endfunction

   mode_e           mode_state;
   mode_e           mode_next;
   logic [IMMW-1:0] lut [DEPTH];

   logic            out_valid_r;
   logic [OPW-1:0]  opcode_r;
   logic [RW-1:0]   reg1_r;
   logic [RW-1:0]   reg2_r;
   logic [IMMW-1:0] imm_r;
   logic            mode_r;

   logic [OPW-1:0]  dec_opcode;
   logic [RW-1:0]   dec_reg1;
   logic [RW-1:0]   dec_reg2;
   logic [IMMW-1:0] dec_imm;
   logic            in_ready;
   logic            accept;

   assign in_ready = !out_valid_r || bus.out_ready;
   assign accept   = bus.in_valid && in_ready && !flush;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      dec_opcode = '0;
      dec_reg1   = '0;
      dec_reg2   = '0;
      dec_imm    = '0;
      if (mode_state == MODE_RR) begin
         dec_opcode = bus.instr[IW-1 -: OPW];
         dec_reg1   = RW'(bus.instr[IW-OPW-1 -: FW]);
         dec_reg2   = RW'(bus.instr[IW-OPW-1-FW -: FW]);
      end else begin
         dec_opcode = OPW'(bus.instr[IW-1:2*RW]);
         dec_reg1   = bus.instr[2*RW-1:RW];
         dec_reg2   = bus.instr[RW-1:0];
         // Read happens before any same-cycle write lands, so decode sees the old entry.
         dec_imm    = lut[dec_reg2];
      end
      mode_next = mode_state;
      if (dec_opcode == OPW'(SWOP))
         mode_next = (mode_state == MODE_RR) ? MODE_RI : MODE_RR;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_state  <= MODE_RR;
         out_valid_r <= 1'b0;
         opcode_r    <= '0;
         reg1_r      <= '0;
         reg2_r      <= '0;
         imm_r       <= '0;
         mode_r      <= 1'b0;
      end else begin
         if (accept)
            mode_state <= mode_next;
         if (flush) begin
            out_valid_r <= 1'b0;
         end else if (accept) begin
            out_valid_r <= 1'b1;
            opcode_r    <= dec_opcode;
            reg1_r      <= dec_reg1;
            reg2_r      <= dec_reg2;
            imm_r       <= dec_imm;
            mode_r      <= (mode_next == MODE_RI);
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // NOTE: the LUT is small and has architected reset contents, so it is reset like ordinary flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            lut[i] <= lut_init(i);
      end else if (lut_we) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_r;
   assign bus.opcode    = opcode_r;
   assign bus.reg1      = reg1_r;
   assign bus.reg2      = reg2_r;
   assign bus.immediate = imm_r;
   assign bus.mode      = mode_r;
   assign mode_q        = (mode_state == MODE_RI);

endmodule

// File: tb/tb_mode_decode_stage.sv
// Scoreboard bench for mode_decode_stage: directed instructions push expected fields,
// a negedge monitor pops and compares on every output transfer.
module tb_mode_decode_stage;

   typedef struct packed {
      logic [4:0] op;
      logic [2:0] r1;
      logic [2:0] r2;
      logic [7:0] imm;
      logic       md;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       lut_we = 1'b0;
   logic [2:0] lut_waddr = '0;
   logic [7:0] lut_wdata = '0;
   logic       mode_q;

   int checks = 0;
   int failures = 0;
   int last_wait = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [7:0] init_lut [8] = '{8'd0, 8'd1, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd127};

   mode_decode_stage_if bus ();

   mode_decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .mode_q    (mode_q),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int op, input int r1, input int r2, input int imm, input int md);
      exp_t e;
      e.op  = 5'(op);
      e.r1  = 3'(r1);
      e.r2  = 3'(r2);
      e.imm = 8'(imm);
      e.md  = 1'(md);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one instruction until accepted, then records its expected decode.
   task automatic issue(input logic [8:0] ins, input exp_t e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.instr    = ins;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n > 50) begin
            check("issue_timeout", 32'(n), 32'd0);
            break;
         end
         @(posedge clk); #1;
      end
      last_wait = n;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got opcode %0d reg2 %0d, expected no output", bus.opcode, bus.reg2);
         end else begin
            mon_e = exp_q.pop_front();
            check("opcode",    32'(bus.opcode),    32'(mon_e.op));
            check("reg1",      32'(bus.reg1),      32'(mon_e.r1));
            check("reg2",      32'(bus.reg2),      32'(mon_e.r2));
            check("immediate", 32'(bus.immediate), 32'(mon_e.imm));
            check("mode",      32'(bus.mode),      32'(mon_e.md));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_opcode",    32'(bus.opcode),    32'd0);
      check("rst_imm",       32'(bus.immediate), 32'd0);
      check("rst_mode_q",    32'(mode_q),        32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      idle(1);

      // Reg-reg decode, one-cycle latency
      issue(9'b00101_10_11, mk(5, 2, 3, 0, 0));
      check("lat_out_valid", 32'(bus.out_valid), 32'd1);

      // Mode switch, then reg-imm decode
      issue(9'b00000_0000, mk(0, 0, 0, 0, 1));
      check("swop_mode_q", 32'(mode_q), 32'd1);
      issue(9'b101_010_110, mk(5, 2, 6, 64, 1));

      // Same-cycle LUT write sees old entry, next decode sees new
      lut_we = 1'b1; lut_waddr = 3'd6; lut_wdata = 8'd200;
      issue(9'b010_011_110, mk(2, 3, 6, 64, 1));
      lut_we = 1'b0;
      issue(9'b100_001_110, mk(4, 1, 6, 200, 1));

      // Backpressure: outputs frozen, then back-to-back throughput
      idle(2);
      bus.out_ready = 1'b0;
      issue(9'b001_001_001, mk(1, 1, 1, 1, 1));
      bus.in_valid = 1'b1;
      bus.instr    = 9'b010_010_010;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready",  32'(bus.in_ready),  32'd0);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_opcode",    32'(bus.opcode),    32'd1);
         check("stall_reg2",      32'(bus.reg2),      32'd1);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      issue(9'b010_010_010, mk(2, 2, 2, 4, 1));
      check("b2b_wait_b", 32'(last_wait), 32'd0);
      issue(9'b011_011_011, mk(3, 3, 3, 8, 1));
      check("b2b_wait_c", 32'(last_wait), 32'd0);
      issue(9'b110_100_111, mk(6, 4, 7, 127, 1));
      check("b2b_wait_d", 32'(last_wait), 32'd0);

      // Flush blocks a same-cycle SWOP accept; mode_q preserved
      idle(2);
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr    = 9'b000_001_010;
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_mode_q",    32'(mode_q),        32'd1);
      issue(9'b011_001_010, mk(3, 1, 2, 4, 1));

      // Flush drops a stalled output
      idle(2);
      bus.out_ready = 1'b0;
      issue(9'b011_000_001, mk(3, 0, 1, 1, 1));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_stall_out_valid", 32'(bus.out_valid), 32'd0);
      void'(exp_q.pop_back());
      bus.out_ready = 1'b1;

      // Asynchronous reset mid-stream
      idle(2);
      bus.out_ready = 1'b0;
      issue(9'b111_101_110, mk(7, 5, 6, 200, 1));
      check("pre_rst_mode_q", 32'(mode_q), 32'd1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_opcode",    32'(bus.opcode),    32'd0);
      check("arst_reg1",      32'(bus.reg1),      32'd0);
      check("arst_reg2",      32'(bus.reg2),      32'd0);
      check("arst_imm",       32'(bus.immediate), 32'd0);
      check("arst_mode",      32'(bus.mode),      32'd0);
      check("arst_mode_q",    32'(mode_q),        32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      idle(1);

      // LUT contents restored
      issue(9'b00000_0000, mk(0, 0, 0, 0, 1));
      for (int i = 0; i < 8; i++)
         issue({3'b001, 3'b000, 3'(i)}, mk(1, 0, i, int'(init_lut[i]), 1));

      idle(3);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
